xor_exhaustive_chk: RTL and testbench



---
 rtl/xor_chk_pkg.sv | 23 ++
 rtl/xor_exhaustive_chk_if.sv | 35 +++
 rtl/xor_chk_pat_ctr.sv | 59 +++++
 rtl/xor_exhaustive_chk.sv | 134 +++++++++++++
 tb/tb_xor_exhaustive_chk.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/xor_chk_pkg.sv
// xor_chk_pkg: shared types and helpers for the exhaustive XOR/XNOR checker.
//   state_e       - checker FSM states
//   SETTLE_W      - width of the per-pattern settle counter
//   MAX_N_IN      - widest supported pattern
//   golden_parity - reference output for a pattern (XOR or XNOR)
package xor_chk_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StApply,
        StCheck,
        StDone
    } state_e;

    localparam int unsigned SETTLE_W = 4;
    localparam int unsigned MAX_N_IN = 16;

    // Zero-extension of pat does not change its parity.
    function automatic logic golden_parity(input logic [MAX_N_IN-1:0] pat, input logic xnor_en);
        return (^pat) ^ xnor_en;
    endfunction

endpackage

// File: rtl/xor_exhaustive_chk_if.sv
// xor_exhaustive_chk_if: start/done handshake plus DUV stimulus/response bundle.
//   start          - single-cycle run request         (master -> slave)
//   duv_i          - output of the gate under test    (master -> slave)
//   pat_o          - pattern driven to the DUV        (slave -> master)
//   busy, done     - run status                       (slave -> master)
//   pass           - done with zero mismatches        (slave -> master)
//   err_cnt        - saturating mismatch count        (slave -> master)
//   first_fail(_vld) - first failing pattern capture  (slave -> master)
// N_IN and ERR_W must match the checker instance bound to the slave modport.
interface xor_exhaustive_chk_if #(
    parameter int unsigned N_IN  = 5,
    parameter int unsigned ERR_W = 8
);

    logic             start;
    logic             duv_i;
    logic [N_IN-1:0]  pat_o;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic [N_IN-1:0]  first_fail;
    logic             first_fail_vld;

    modport master (
        output start, duv_i,
        input  pat_o, busy, done, pass, err_cnt, first_fail, first_fail_vld
    );

    modport slave (
        input  start, duv_i,
        output pat_o, busy, done, pass, err_cnt, first_fail, first_fail_vld
    );

endinterface

// File: rtl/xor_chk_pat_ctr.sv
// xor_chk_pat_ctr: pattern and settle counters for the exhaustive checker.
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr         - zero both counters (start of run)
//   settle_inc  - advance the settle counter
//   pat_inc     - advance the pattern, restart the settle counter
//   pat         - current pattern
//   is_last     - pattern is all ones (terminal pattern)
//   settle_exp  - settle counter has reached SETTLE-1
module xor_chk_pat_ctr
    import xor_chk_pkg::*;
#(
    parameter int unsigned N_IN   = 5,
    parameter int unsigned SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            settle_inc,
    input  logic            pat_inc,
    output logic [N_IN-1:0] pat,
    output logic            is_last,
    output logic            settle_exp
);

    localparam logic [SETTLE_W-1:0] SettleLast = SETTLE_W'(SETTLE - 1);

    logic [N_IN-1:0]     pat_q, pat_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;

    always_comb begin
        pat_d    = pat_q;
        settle_d = settle_q;
        if (clr) begin
            pat_d    = '0;
            settle_d = '0;
        end else if (pat_inc) begin
            // Never issued on the all-ones pattern, so no wrap occurs.
            pat_d    = pat_q + N_IN'(1);
            settle_d = '0;
        end else if (settle_inc) begin
            settle_d = settle_q + SETTLE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q    <= '0;
            settle_q <= '0;
        end else begin
            pat_q    <= pat_d;
            settle_q <= settle_d;
        end
    end

    assign pat        = pat_q;
    assign is_last    = &pat_q;
    assign settle_exp = (settle_q == SettleLast);

endmodule

// File: rtl/xor_exhaustive_chk.sv
// xor_exhaustive_chk: on-chip exhaustive stimulus generator and self-checker for an
// N_IN-input XOR/XNOR gate. Walks every pattern, holds each for SETTLE cycles, then
// compares the DUV output with the golden parity in a single CHECK cycle.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - slave side of xor_exhaustive_chk_if (start, duv_i in; pat_o, busy,
//                done, pass, err_cnt, first_fail, first_fail_vld out)
// Optional: define XOR_CHK_STOP_ON_FAIL_EN to end the run on the first mismatch.
module xor_exhaustive_chk
    import xor_chk_pkg::*;
#(
    parameter int unsigned N_IN        = 5,
    parameter int unsigned SETTLE      = 1,
    parameter int unsigned ERR_W       = 8,
    parameter int unsigned EXPECT_XNOR = 0
) (
    input logic                 clk,
    input logic                 rst_n,
    xor_exhaustive_chk_if.slave bus
);

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [N_IN-1:0]  ff_q, ff_d;
    logic             ffv_q, ffv_d;

    logic             ctr_clr, settle_inc, pat_inc;
    logic [N_IN-1:0]  pat;
    logic             is_last, settle_exp;
    logic             golden, mismatch, stop_run;

    xor_chk_pat_ctr #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) u_pat_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (ctr_clr),
        .settle_inc (settle_inc),
        .pat_inc    (pat_inc),
        .pat        (pat),
        .is_last    (is_last),
        .settle_exp (settle_exp)
    );

    assign golden   = golden_parity(MAX_N_IN'(pat), EXPECT_XNOR != 0);
    assign mismatch = (bus.duv_i != golden);

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        ff_d       = ff_q;
        ffv_d      = ffv_q;
        ctr_clr    = 1'b0;
        settle_inc = 1'b0;
        pat_inc    = 1'b0;
        stop_run   = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d = StApply;
                    ctr_clr = 1'b1;
                    err_d   = '0;
                    ff_d    = '0;
                    ffv_d   = 1'b0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            StApply: begin
                settle_inc = 1'b1;
                if (settle_exp) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (mismatch) begin
                    if (err_q != '1) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    if (!ffv_q) begin
                        ff_d  = pat;
                        ffv_d = 1'b1;
                    end
`ifdef XOR_CHK_STOP_ON_FAIL_EN
                    stop_run = 1'b1;
`endif
                end
                if (is_last || stop_run) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    pat_inc = 1'b1;
                    state_d = StApply;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
            ff_q    <= '0;
            ffv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            ffv_q   <= ffv_d;
        end
    end

    assign bus.pat_o          = pat;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = done_q && (err_q == '0);
    assign bus.err_cnt        = err_q;
    assign bus.first_fail     = ff_q;
    assign bus.first_fail_vld = ffv_q;

endmodule

// File: tb/tb_xor_exhaustive_chk.sv
// tb_xor_exhaustive_chk: directed bench for xor_exhaustive_chk. Five checker instances
// share one clock/reset, each beside a different behavioural DUV:
//   a: N_IN=3 SETTLE=1 good XOR      b: N_IN=5 DUV stuck at 0
//   c: N_IN=2 ERR_W=2 XNOR DUV       d: N_IN=3 SETTLE=3 good XOR
//   e: N_IN=3 DUV stuck at 1
// Expected results follow XOR_CHK_STOP_ON_FAIL_EN when it is defined.
module tb_xor_exhaustive_chk;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [4:0]  start_v;
    logic [4:0]  done_v;
    logic [15:0] pat_v [5];

`ifdef XOR_CHK_STOP_ON_FAIL_EN
    localparam int BCyc = 4,  BErr = 1,  BPat = 1,  BFf = 1;
    localparam int CCyc = 2,  CErr = 1,  CPat = 0;
    localparam int ECyc = 2,  EErr = 1,  EPat = 0;
`else
    localparam int BCyc = 64, BErr = 16, BPat = 31, BFf = 1;
    localparam int CCyc = 8,  CErr = 3,  CPat = 3;
    localparam int ECyc = 16, EErr = 4,  EPat = 7;
`endif

    xor_exhaustive_chk_if #(.N_IN(3), .ERR_W(8)) if_a ();
    xor_exhaustive_chk_if #(.N_IN(5), .ERR_W(8)) if_b ();
    xor_exhaustive_chk_if #(.N_IN(2), .ERR_W(2)) if_c ();
    xor_exhaustive_chk_if #(.N_IN(3), .ERR_W(8)) if_d ();
    xor_exhaustive_chk_if #(.N_IN(3), .ERR_W(8)) if_e ();

    assign if_a.duv_i = ^if_a.pat_o;
    assign if_b.duv_i = 1'b0;
    assign if_c.duv_i = ~^if_c.pat_o;
    assign if_d.duv_i = ^if_d.pat_o;
    assign if_e.duv_i = 1'b1;

    assign if_a.start = start_v[0];
    assign if_b.start = start_v[1];
    assign if_c.start = start_v[2];
    assign if_d.start = start_v[3];
    assign if_e.start = start_v[4];

    assign done_v = {if_e.done, if_d.done, if_c.done, if_b.done, if_a.done};
    assign pat_v[0] = 16'(if_a.pat_o);
    assign pat_v[1] = 16'(if_b.pat_o);
    assign pat_v[2] = 16'(if_c.pat_o);
    assign pat_v[3] = 16'(if_d.pat_o);
    assign pat_v[4] = 16'(if_e.pat_o);

    xor_exhaustive_chk #(.N_IN(3), .SETTLE(1), .ERR_W(8), .EXPECT_XNOR(0)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    xor_exhaustive_chk #(.N_IN(5), .SETTLE(1), .ERR_W(8), .EXPECT_XNOR(0)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b.slave));
    xor_exhaustive_chk #(.N_IN(2), .SETTLE(1), .ERR_W(2), .EXPECT_XNOR(0)) u_c (
        .clk(clk), .rst_n(rst_n), .bus(if_c.slave));
    xor_exhaustive_chk #(.N_IN(3), .SETTLE(3), .ERR_W(8), .EXPECT_XNOR(0)) u_d (
        .clk(clk), .rst_n(rst_n), .bus(if_d.slave));
    xor_exhaustive_chk #(.N_IN(3), .SETTLE(1), .ERR_W(8), .EXPECT_XNOR(0)) u_e (
        .clk(clk), .rst_n(rst_n), .bus(if_e.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse start on instance idx, then count edges until done. While waiting, pat_o
    // must equal cyc/(settle+1). Returns cyc == bound if done never rose.
    task automatic run(input int idx, input int settle, input int bound, output int cyc,
                       output int pat_bad, output logic done_after);
        @(posedge clk);
        #1 start_v[idx] = 1'b1;
        @(posedge clk);
        #1 start_v[idx] = 1'b0;
        done_after = done_v[idx];
        cyc = 0;
        pat_bad = 0;
        while (cyc < bound) begin
            if (done_v[idx] === 1'b1) break;
            if (pat_v[idx] !== 16'(cyc / (settle + 1))) pat_bad++;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        int   cyc;
        int   pat_bad;
        logic done_after;

        start_v = '0;
        rst_n   = 1'b0;
        #12;
        check("rst_pat",  if_a.pat_o, 0);
        check("rst_busy", if_a.busy, 0);
        check("rst_done", if_a.done, 0);
        check("rst_pass", if_a.pass, 0);
        check("rst_err",  if_a.err_cnt, 0);
        check("rst_ff",   if_a.first_fail, 0);
        check("rst_ffv",  if_a.first_fail_vld, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Good 3-input XOR
        run(0, 1, 100, cyc, pat_bad, done_after);
        check("a_cycles", cyc, 16);
        check("a_pat_seq", pat_bad, 0);
        check("a_err", if_a.err_cnt, 0);
        check("a_pass", if_a.pass, 1);
        check("a_ffv", if_a.first_fail_vld, 0);
        check("a_busy", if_a.busy, 0);
        check("a_pat_end", if_a.pat_o, 7);
        repeat (5) @(posedge clk);
        #1;
        check("a_done_held", if_a.done, 1);
        check("a_pass_held", if_a.pass, 1);

        // 5-input DUV replaced by constant 0
        run(1, 1, 200, cyc, pat_bad, done_after);
        check("b_cycles", cyc, BCyc);
        check("b_pat_seq", pat_bad, 0);
        check("b_err", if_b.err_cnt, BErr);
        check("b_ff", if_b.first_fail, BFf);
        check("b_ffv", if_b.first_fail_vld, 1);
        check("b_pass", if_b.pass, 0);
        check("b_pat_end", if_b.pat_o, BPat);

        // XNOR DUV against XOR golden, 2-bit saturating counter
        run(2, 1, 100, cyc, pat_bad, done_after);
        check("c_cycles", cyc, CCyc);
        check("c_err_sat", if_c.err_cnt, CErr);
        check("c_ff", if_c.first_fail, 0);
        check("c_ffv", if_c.first_fail_vld, 1);
        check("c_pass", if_c.pass, 0);
        check("c_pat_end", if_c.pat_o, CPat);

        // SETTLE=3, then a rerun from DONE
        run(3, 3, 200, cyc, pat_bad, done_after);
        check("d_cycles", cyc, 32);
        check("d_pat_seq", pat_bad, 0);
        check("d_pass", if_d.pass, 1);
        run(3, 3, 200, cyc, pat_bad, done_after);
        check("d_done_clr", done_after, 0);
        check("d_busy_rerun", cyc, 32);
        check("d_pat_seq2", pat_bad, 0);
        check("d_pass2", if_d.pass, 1);

        // DUV stuck at 1
        run(4, 1, 100, cyc, pat_bad, done_after);
        check("e_cycles", cyc, ECyc);
        check("e_err", if_e.err_cnt, EErr);
        check("e_ff", if_e.first_fail, 0);
        check("e_ffv", if_e.first_fail_vld, 1);
        check("e_done", if_e.done, 1);
        check("e_pat_end", if_e.pat_o, EPat);

        // Second start mid-run is ignored; reset mid-run clears everything
        @(posedge clk);
        #1 start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1 start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        check("ign_pat", if_a.pat_o, 2);
        check("ign_busy", if_a.busy, 1);
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_pat", if_a.pat_o, 4);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_pat", if_a.pat_o, 0);
        check("mid_rst_busy", if_a.busy, 0);
        check("mid_rst_done_e", if_e.done, 0);
        check("mid_rst_err_e", if_e.err_cnt, 0);
        check("mid_rst_ffv_e", if_e.first_fail_vld, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run(0, 1, 100, cyc, pat_bad, done_after);
        check("a_rerun_cycles", cyc, 16);
        check("a_rerun_pat_seq", pat_bad, 0);
        check("a_rerun_pass", if_a.pass, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
